// File: rtl/mem_burst_reader.sv
// Burst read DMA stage: streams num_beats memory rows from base_addr into a
// credit-guarded capture FIFO that drains through a valid/ready output.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module mem_burst_reader #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int BANDWIDTH  = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic [LEN_WIDTH-1:0]            num_beats,
    output logic                            busy,
    output logic                            done,
    output logic                            mem_read,
    output logic [ADDR_WIDTH-1:0]           mem_address,
    input  logic [BANDWIDTH*DATA_WIDTH-1:0] mem_readdata,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BANDWIDTH*DATA_WIDTH-1:0] out_data,
    output logic                            out_last
);

    localparam int RW = BANDWIDTH * DATA_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   next_addr, issue_addr;
    logic [LEN_WIDTH-1:0]    issue_cnt, ret_cnt, issue_left;
    logic                    pending;
    logic [RW-1:0]           fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_last;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           fifo_count;
    logic [CW:0]             credit;
    logic                    accept, issue, push, pop, last_pop, drained;

    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_last  = out_valid & fifo_last[rd_ptr];

    always_comb begin
        push       = pending;
        pop        = out_valid & out_ready;
        last_pop   = pop & fifo_last[rd_ptr];
        accept     = (state == IDLE) && start;
        issue_addr = accept ? base_addr : next_addr;
        issue_left = accept ? num_beats : issue_cnt;
        // Reads already committed: buffered, returning now, and launched now.
        credit     = {1'b0, fifo_count} + (CW+1)'(pending) + (CW+1)'(mem_read);
        drained    = (issue_cnt == '0) && (ret_cnt == '0) && !pending &&
                     !mem_read && (fifo_count == '0);
        issue      = 1'b0;
        if (accept)
            issue = (num_beats != '0);
        else if (state == RUN)
            issue = (issue_cnt != '0) && (credit < (CW+1)'(FIFO_DEPTH));
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            // An empty request idles one cycle in RUN so done follows start by two.
            RUN:     if (last_pop || drained) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_address <= '0;
            next_addr   <= '0;
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            pending     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            fifo_last   <= '0;
        end else begin
            state    <= state_next;
            mem_read <= issue;
            pending  <= mem_read;
            if (accept) begin
                next_addr <= base_addr;
                issue_cnt <= num_beats;
                ret_cnt   <= num_beats;
            end
            if (issue) begin
                mem_address <= issue_addr;
                next_addr   <= issue_addr + ADDR_WIDTH'(1);
                issue_cnt   <= issue_left - LEN_WIDTH'(1);
            end
            if (push) begin
                fifo_last[wr_ptr] <= (ret_cnt == LEN_WIDTH'(1));
                wr_ptr            <= wr_ptr + PW'(1);
                ret_cnt           <= ret_cnt - LEN_WIDTH'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            fifo_data[wr_ptr] <= mem_readdata;
    end

endmodule
